ysyx_041461_div: RTL and testbench



---
 rtl/ysyx_041461_div_pkg.sv | 16 +
 rtl/ysyx_041461_div_step.sv | 22 ++
 rtl/ysyx_041461_div.sv | 171 +++++++++++++++++
 tb/tb_ysyx_041461_div.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state
// encodings and the iteration counts for 64-bit and word operations.
package ysyx_041461_div_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    localparam int DIV_N64 = 64;
    localparam int DIV_N32 = 32;

endpackage

// File: rtl/ysyx_041461_div_step.sv
// One restoring-division step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference when it does not borrow.
module ysyx_041461_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   part_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);

    logic [XLEN+1:0] diff;
    logic            step_unused;

    // Subtract on N+1 bits plus a borrow bit; a clear borrow means quotient bit 1.
    assign diff   = {1'b0, part_i} - {2'b00, divisor_i};
    assign qbit_o = ~diff[XLEN+1];
    // Whenever no borrow occurs the difference is below the divisor, so its top bit is zero.
    assign rem_o  = qbit_o ? diff[XLEN-1:0] : part_i[XLEN-1:0];
    assign step_unused = diff[XLEN];

endmodule

// File: rtl/ysyx_041461_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
// W variants. One quotient bit per cycle; divide-by-zero and signed overflow
// skip the iteration.
//
// Handshake: an operation is accepted on a rising edge where DIV_valid_in is
// high, DIV_ready is high (state IDLE) and DIV_flush is low. Operands are
// sampled only on that edge. DIV_valid_out is a one-cycle pulse in DONE and
// DIV_quotient/DIV_remainder are valid in that cycle (they hold afterwards).
module ysyx_041461_div
    import ysyx_041461_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            DIV_valid_in,
    input  logic            DIV_signed,
    input  logic            DIV_word,
    input  logic [XLEN-1:0] DIV_dividend,
    input  logic [XLEN-1:0] DIV_divisor,
    input  logic            DIV_flush,
    output logic            DIV_ready,
    output logic            DIV_valid_out,
    output logic [XLEN-1:0] DIV_quotient,
    output logic [XLEN-1:0] DIV_remainder,
    output div_state_e      DIV_state_o
);

    localparam int CW = $clog2(XLEN + 1);

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic            signed_q, word_q;
    logic [XLEN-1:0] dvd_q, dvs_q;
    logic [XLEN-1:0] quo_q, rem_q, abs_dvs_q;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] quotient_q, remainder_q;
    logic            valid_q;

    logic [XLEN-1:0] eff_dvd_d, eff_dvs_d, abs_dvd_d, abs_dvs_d, most_neg_d;
    logic            sign_dvd_d, sign_dvs_d, dvs_zero_d, ovf_d;
    logic [XLEN-1:0] fix_quo_d, fix_rem_d;
    logic [XLEN-1:0] step_rem;
    logic            step_qbit;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Operand preparation: effective operands, signs, magnitudes and early-exit detection.
    always_comb begin
        eff_dvd_d = dvd_q;
        eff_dvs_d = dvs_q;
        if (word_q) begin
            eff_dvd_d = signed_q ? sext32(dvd_q[31:0]) : {{(XLEN-32){1'b0}}, dvd_q[31:0]};
            eff_dvs_d = signed_q ? sext32(dvs_q[31:0]) : {{(XLEN-32){1'b0}}, dvs_q[31:0]};
        end
        sign_dvd_d = signed_q & eff_dvd_d[XLEN-1];
        sign_dvs_d = signed_q & eff_dvs_d[XLEN-1];
        abs_dvd_d  = sign_dvd_d ? -eff_dvd_d : eff_dvd_d;
        abs_dvs_d  = sign_dvs_d ? -eff_dvs_d : eff_dvs_d;
        most_neg_d = word_q ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        dvs_zero_d = (eff_dvs_d == '0);
        ovf_d      = signed_q && (eff_dvs_d == '1) && (eff_dvd_d == most_neg_d);
    end

    // Sign fix-up and word-mode sign extension of the raw results.
    always_comb begin
        fix_quo_d = neg_quo_q ? -quo_q : quo_q;
        fix_rem_d = neg_rem_q ? -rem_q : rem_q;
        if (word_q) begin
            fix_quo_d = sext32(fix_quo_d[31:0]);
            fix_rem_d = sext32(fix_rem_d[31:0]);
        end
    end

    ysyx_041461_div_step #(.XLEN(XLEN)) u_step (
        .part_i    ({rem_q, quo_q[XLEN-1]}),
        .divisor_i (abs_dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Control FSM together with the datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            word_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            abs_dvs_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (DIV_flush && state_q != DIV_IDLE) begin
                state_q <= DIV_IDLE;
            end else begin
                case (state_q)
                    DIV_IDLE: begin
                        if (DIV_valid_in && !DIV_flush) begin
                            signed_q <= DIV_signed;
                            word_q   <= DIV_word;
                            dvd_q    <= DIV_dividend;
                            dvs_q    <= DIV_divisor;
                            state_q  <= DIV_PREP;
                        end
                    end
                    DIV_PREP: begin
                        // Early exits preload the final raw results and reuse FIX
                        // for word sign extension, keeping their latency at two edges.
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                        if (dvs_zero_d) begin
                            quo_q   <= '1;
                            rem_q   <= eff_dvd_d;
                            state_q <= DIV_FIX;
                        end else if (ovf_d) begin
                            quo_q   <= eff_dvd_d;
                            rem_q   <= '0;
                            state_q <= DIV_FIX;
                        end else begin
                            neg_quo_q <= sign_dvd_d ^ sign_dvs_d;
                            neg_rem_q <= sign_dvd_d;
                            abs_dvs_q <= abs_dvs_d;
                            // Word dividends are moved to the top so the shift-out bit is always the MSB.
                            quo_q     <= word_q ? (abs_dvd_d << (XLEN - 32)) : abs_dvd_d;
                            rem_q     <= '0;
                            cnt_q     <= word_q ? CW'(DIV_N32) : CW'(XLEN);
                            state_q   <= DIV_CALC;
                        end
                    end
                    DIV_CALC: begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[XLEN-2:0], step_qbit};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q <= DIV_FIX;
                        end
                    end
                    DIV_FIX: begin
                        quotient_q  <= fix_quo_d;
                        remainder_q <= fix_rem_d;
                        valid_q     <= 1'b1;
                        state_q     <= DIV_DONE;
                    end
                    DIV_DONE: begin
                        state_q <= DIV_IDLE;
                    end
                    default: begin
                        state_q <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    assign DIV_ready     = (state_q == DIV_IDLE);
    assign DIV_valid_out = valid_q;
    assign DIV_quotient  = quotient_q;
    assign DIV_remainder = remainder_q;
    assign DIV_state_o   = state_q;

endmodule

// File: tb/tb_ysyx_041461_div.sv
// Bench for ysyx_041461_div: directed vectors with literal expectations,
// flush/reset recovery, and back-to-back mixed operations checked against an
// arithmetic reference model through an expected queue.
module tb_ysyx_041461_div;
  import ysyx_041461_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        DIV_valid_in, DIV_signed, DIV_word, DIV_flush;
  logic [63:0] DIV_dividend, DIV_divisor;
  logic        DIV_ready, DIV_valid_out;
  logic [63:0] DIV_quotient, DIV_remainder;
  div_state_e  DIV_state_o;

  ysyx_041461_div #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .DIV_valid_in  (DIV_valid_in),
    .DIV_signed    (DIV_signed),
    .DIV_word      (DIV_word),
    .DIV_dividend  (DIV_dividend),
    .DIV_divisor   (DIV_divisor),
    .DIV_flush     (DIV_flush),
    .DIV_ready     (DIV_ready),
    .DIV_valid_out (DIV_valid_out),
    .DIV_quotient  (DIV_quotient),
    .DIV_remainder (DIV_remainder),
    .DIV_state_o   (DIV_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_r[$];
  int          exp_lat[$];
  longint      exp_acc[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // RV64M reference: results and latency derived from the arithmetic rules.
  function automatic void ref_div(input logic s, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output int lat);
    if (w) begin
      logic [31:0] a32, b32, q32, r32;
      int sa, sb;
      a32 = a[31:0];
      b32 = b[31:0];
      sa = a32;
      sb = b32;
      lat = 34;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; lat = 2;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; lat = 2;
      end else if (s) begin
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      longint sa, sb;
      sa = a;
      sb = b;
      lat = 66;
      if (b == 64'd0) begin
        q = '1; r = a; lat = 2;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; lat = 2;
      end else if (s) begin
        q = sa / sb; r = sa % sb;
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // accept monitor: pushes model results for every accepted operation
  always @(posedge clk) begin
    logic [63:0] mq, mr;
    int ml;
    cyc = cyc + 1;
    if (!rst && DIV_valid_in && DIV_ready && !DIV_flush) begin
      ref_div(DIV_signed, DIV_word, DIV_dividend, DIV_divisor, mq, mr, ml);
      exp_q.push_back(mq);
      exp_r.push_back(mr);
      exp_lat.push_back(ml);
      exp_acc.push_back(cyc);
    end
  end

  // scoreboard compare: every valid_out pulse against the queue head
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (DIV_valid_out) begin
        check_int("valid_pulse_width", int'(prev_v), 0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got quotient %h with no pending operation", DIV_quotient);
        end else begin
          check64("sb_quotient", DIV_quotient, exp_q.pop_front());
          check64("sb_remainder", DIV_remainder, exp_r.pop_front());
          check_int("sb_latency", cyc - exp_acc.pop_front(), longint'(exp_lat.pop_front()));
        end
      end
      prev_v = DIV_valid_out;
    end
  end

  task automatic drop_pending();
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_back());
      void'(exp_r.pop_back());
      void'(exp_lat.pop_back());
      void'(exp_acc.pop_back());
    end
  endtask

  // driver: one directed operation with literal expectations
  task automatic run_op(input string name, input logic s, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] qe, input logic [63:0] re, input int le);
    longint acc;
    int k;
    bit ready_hi;
    @(negedge clk);
    DIV_signed = s; DIV_word = w; DIV_dividend = a; DIV_divisor = b; DIV_valid_in = 1'b1;
    @(negedge clk);
    DIV_valid_in = 1'b0;
    acc = cyc;
    DIV_signed = 1'($urandom_range(0, 1));
    DIV_word = 1'($urandom_range(0, 1));
    DIV_dividend = {$urandom, $urandom};
    DIV_divisor = {$urandom, $urandom};
    ready_hi = 1'b0;
    k = 0;
    while (!DIV_valid_out && k < 300) begin
      if (DIV_ready) ready_hi = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!DIV_valid_out) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no valid_out after %0d cycles, expected within %0d", name, k, le);
    end else begin
      check64({name, "_quotient"}, DIV_quotient, qe);
      check64({name, "_remainder"}, DIV_remainder, re);
      check_int({name, "_latency"}, cyc - acc, longint'(le));
      check_int({name, "_ready_low"}, longint'(ready_hi), 0);
    end
  endtask

  logic [63:0] rq, rr;
  int          rl;

  initial begin
    rst = 1'b1;
    DIV_valid_in = 1'b0; DIV_signed = 1'b0; DIV_word = 1'b0; DIV_flush = 1'b0;
    DIV_dividend = '0; DIV_divisor = '0;
    repeat (3) @(negedge clk);
    check_int("reset_valid_out", longint'(DIV_valid_out), 0);
    check_int("reset_ready", longint'(DIV_ready), 1);
    check64("reset_quotient", DIV_quotient, 64'd0);
    check64("reset_remainder", DIV_remainder, 64'd0);
    check_int("reset_state", longint'(DIV_state_o), longint'(DIV_IDLE));
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66);
    run_op("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("div_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
    run_op("div_by_zero", 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2);
    run_op("div_overflow", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 2);
    run_op("divuw", 1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd0, 34);
    run_op("divw_overflow", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 64'd0, 2);
    run_op("remuw_by_zero", 1'b0, 1'b1, 64'h0000_0000_8000_0001, 64'h1234_5678_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 2);

    // flush together with valid_in must not accept
    @(negedge clk);
    DIV_valid_in = 1'b1; DIV_flush = 1'b1; DIV_signed = 1'b0; DIV_word = 1'b0;
    DIV_dividend = 64'd50; DIV_divisor = 64'd5;
    @(negedge clk);
    DIV_valid_in = 1'b0; DIV_flush = 1'b0;
    check_int("flush_blocks_accept_ready", longint'(DIV_ready), 1);

    // flush 10 cycles into CALC
    @(negedge clk);
    DIV_valid_in = 1'b1; DIV_dividend = 64'd1000; DIV_divisor = 64'd3;
    @(negedge clk);
    DIV_valid_in = 1'b0;
    repeat (10) @(negedge clk);
    DIV_flush = 1'b1;
    drop_pending();
    @(negedge clk);
    DIV_flush = 1'b0;
    check_int("flush_ready", longint'(DIV_ready), 1);
    check_int("flush_no_valid", longint'(DIV_valid_out), 0);
    repeat (80) @(negedge clk);
    run_op("after_flush_9_3", 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 66);

    // reset mid-CALC
    @(negedge clk);
    DIV_valid_in = 1'b1; DIV_signed = 1'b1; DIV_word = 1'b0;
    DIV_dividend = 64'd12345; DIV_divisor = 64'd67;
    @(negedge clk);
    DIV_valid_in = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    drop_pending();
    @(negedge clk);
    rst = 1'b0;
    check_int("midreset_ready", longint'(DIV_ready), 1);
    check_int("midreset_valid", longint'(DIV_valid_out), 0);
    check64("midreset_quotient", DIV_quotient, 64'd0);
    check64("midreset_remainder", DIV_remainder, 64'd0);
    repeat (80) @(negedge clk);
    run_op("after_reset_20_6", 1'b0, 1'b0, 64'd20, 64'd6, 64'd3, 64'd2, 66);

    // back-to-back mixed operations with valid_in held high
    begin
      longint prev_acc, acc;
      int prev_lat, k;
      prev_acc = 0;
      prev_lat = 0;
      @(negedge clk);
      for (int i = 0; i < 400; i++) begin
        int cls;
        logic s, w;
        logic [63:0] a, b;
        cls = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} >> $urandom_range(0, 63);
        if (cls == 0) begin
          b = w ? {$urandom, 32'd0} : 64'd0;
        end else if (cls == 1) begin
          s = 1'b1;
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end else if (cls == 2) begin
          a = a >> $urandom_range(0, 63);
        end
        DIV_signed = s; DIV_word = w; DIV_dividend = a; DIV_divisor = b; DIV_valid_in = 1'b1;
        k = 0;
        while (!DIV_ready && k < 200) begin
          @(negedge clk);
          k++;
        end
        if (!DIV_ready) begin
          n_vec++;
          n_err++;
          $display("FAIL b2b_ready_timeout: ready low for %0d cycles at op %0d", k, i);
        end
        @(negedge clk);
        acc = cyc;
        if (i > 0) check_int("b2b_accept_spacing", acc - prev_acc, longint'(prev_lat + 2));
        ref_div(s, w, a, b, rq, rr, rl);
        prev_acc = acc;
        prev_lat = rl;
      end
      DIV_valid_in = 1'b0;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check_int("b2b_drained", longint'(exp_q.size()), 0);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
